// File: rtl/pack_buffer.sv
// Frame FIFO between the trace packet assembler and the output handler.
// Each synchronized rising edge of PkAvail stores one 128-bit frame; FrameNext pops the head.
module pack_buffer #(
    parameter int BUFFLENLOG2 = 9
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   PkAvail,
    input  logic [127:0]           Packet,
    output logic [127:0]           Frame,
    input  logic                   FrameNext,
    output logic [BUFFLENLOG2-1:0] FramesCnt,
    output logic                   DataOverf
);

    localparam int AW    = BUFFLENLOG2;
    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] MAXCNT = (AW+1)'(DEPTH - 1);

    logic          sync1_q, sync2_q, edge_q;
    logic [AW-1:0] wrPtr_q, wrPtr_d;
    logic [AW-1:0] rdPtr_q, rdPtr_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          wrPend_q, wrPend_d;
    logic          overf_q, overf_d;
    logic [127:0]  frame_q;
    logic [127:0]  mem [DEPTH];

    logic          wrReq, full, doWrite, doPop;
    logic [AW:0]   stored;

    // A write lands in RAM one edge before it shows in the count, so fullness
    // must include the frame still waiting to become visible.
    always_comb begin
        wrReq    = sync2_q & ~edge_q;
        stored   = {1'b0, cnt_q} + {{AW{1'b0}}, wrPend_q};
        full     = (stored == MAXCNT);
        doWrite  = wrReq & ~full;
        doPop    = FrameNext & (cnt_q != '0);
        wrPtr_d  = wrPtr_q + AW'(doWrite);
        rdPtr_d  = rdPtr_q + AW'(doPop);
        wrPend_d = doWrite;
        cnt_d    = cnt_q + AW'(wrPend_q) - AW'(doPop);
        overf_d  = overf_q | (wrReq & full);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            edge_q   <= 1'b0;
            wrPtr_q  <= '0;
            rdPtr_q  <= '0;
            cnt_q    <= '0;
            wrPend_q <= 1'b0;
            overf_q  <= 1'b0;
        end else begin
            sync1_q  <= PkAvail;
            sync2_q  <= sync1_q;
            edge_q   <= sync2_q;
            wrPtr_q  <= wrPtr_d;
            rdPtr_q  <= rdPtr_d;
            cnt_q    <= cnt_d;
            wrPend_q <= wrPend_d;
            overf_q  <= overf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (doWrite) begin
            mem[wrPtr_q] <= Packet;
        end
    end

    // Read-before-write: a same-address write on this edge is seen next cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_q <= '0;
        end else begin
            frame_q <= mem[rdPtr_q];
        end
    end

    assign Frame     = frame_q;
    assign FramesCnt = cnt_q;
    assign DataOverf = overf_q;

endmodule

// File: tb/tb_pack_buffer.sv
// Self-checking bench for pack_buffer: vector table for ordering, scoreboard queue
// for every stored frame, and hand-written sequences for reset, overflow and wrap.
`timescale 1ns/1ps
module tb_pack_buffer;

    typedef struct {
        logic [127:0] packet;
        int           hold;
        logic [8:0]   expCnt;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         PkAvail;
    logic [127:0] Packet;
    logic [127:0] Frame;
    logic         FrameNext;
    logic [8:0]   FramesCnt;
    logic         DataOverf;

    int assertCount = 0;
    int failCount   = 0;
    logic [127:0] sbQueue [$];
    vec_t         vecs [3];

    pack_buffer #(.BUFFLENLOG2(9)) dut (
        .clk       (clk),
        .rst       (rst),
        .PkAvail   (PkAvail),
        .Packet    (Packet),
        .Frame     (Frame),
        .FrameNext (FrameNext),
        .FramesCnt (FramesCnt),
        .DataOverf (DataOverf)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one PkAvail pulse; returns once the write is visible in FramesCnt.
    task automatic applyStimulus(input logic [127:0] pkt, input int hold);
        @(negedge clk);
        Packet  = pkt;
        PkAvail = 1'b1;
        repeat (hold) @(negedge clk);
        PkAvail = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic popFrame();
        FrameNext = 1'b1;
        @(negedge clk);
        FrameNext = 1'b0;
        @(negedge clk);
    endtask

    task automatic drainAll(input string name);
        logic [127:0] exp;
        while (sbQueue.size() > 0) begin
            exp = sbQueue.pop_front();
            checkOutput({name, "_frame"}, Frame, exp);
            popFrame();
            checkOutput({name, "_cnt"}, 128'(FramesCnt), 128'(sbQueue.size()));
        end
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [127:0] pkt;

        vecs[0] = '{packet: 128'h10, hold: 4,  expCnt: 9'd1};
        vecs[1] = '{packet: 128'h20, hold: 20, expCnt: 9'd2};
        vecs[2] = '{packet: 128'h30, hold: 6,  expCnt: 9'd3};

        rst = 1'b0; PkAvail = 1'b0; FrameNext = 1'b0; Packet = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset_cnt",   128'(FramesCnt), 128'd0);
        checkOutput("reset_overf", 128'(DataOverf), 128'd0);
        checkOutput("reset_frame", Frame, 128'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Pop while empty is ignored.
        popFrame();
        checkOutput("empty_pop_cnt", 128'(FramesCnt), 128'd0);

        // Single frame: visible within 4 cycles of PkAvail rising.
        pkt = 128'h18071607150614051304120311021001;
        Packet = pkt; PkAvail = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("single_cnt",   128'(FramesCnt), 128'd1);
        checkOutput("single_frame", Frame, pkt);
        PkAvail = 1'b0;
        repeat (3) @(negedge clk);
        popFrame();
        checkOutput("single_pop_cnt", 128'(FramesCnt), 128'd0);

        // Ordering; the 20-cycle hold must still produce exactly one write.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(vecs[i].packet, vecs[i].hold);
            sbQueue.push_back(vecs[i].packet);
            checkOutput("order_cnt", 128'(FramesCnt), 128'(vecs[i].expCnt));
        end
        drainAll("order");

        // Fill to capacity, then one more write is dropped and flagged.
        for (int i = 1; i <= 511; i++) begin
            pkt = {96'hC0FFEE00_11223344_55667788, 32'(i)};
            applyStimulus(pkt, 4);
            sbQueue.push_back(pkt);
            checkOutput("fill_cnt", 128'(FramesCnt), 128'(i));
        end
        checkOutput("fill_overf", 128'(DataOverf), 128'd0);
        applyStimulus({96'hDEAD, 32'd512}, 4);
        checkOutput("overflow_cnt",   128'(FramesCnt), 128'd511);
        checkOutput("overflow_overf", 128'(DataOverf), 128'd1);
        drainAll("overflow_drain");
        checkOutput("overf_sticky", 128'(DataOverf), 128'd1);

        // Reset mid-run with 3 frames stored.
        for (int i = 0; i < 3; i++) applyStimulus({96'h0, 32'hAB00 + 32'(i)}, 4);
        checkOutput("prereset_cnt", 128'(FramesCnt), 128'd3);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("midreset_cnt",   128'(FramesCnt), 128'd0);
        checkOutput("midreset_overf", 128'(DataOverf), 128'd0);
        checkOutput("midreset_frame", Frame, 128'd0);
        sbQueue.delete();
        @(negedge clk);
        rst = 1'b1;
        pkt = 128'hFEEDFACE_CAFEBABE_01234567_89ABCDEF;
        applyStimulus(pkt, 4);
        sbQueue.push_back(pkt);
        checkOutput("postreset_cnt", 128'(FramesCnt), 128'd1);
        drainAll("postreset");

        // Half-full FIFO with simultaneous visible write and pop.
        for (int i = 0; i < 256; i++) begin
            pkt = {$urandom, $urandom, $urandom, 32'(i)};
            applyStimulus(pkt, 4);
            sbQueue.push_back(pkt);
        end
        checkOutput("half_cnt", 128'(FramesCnt), 128'd256);
        for (int i = 0; i < 1000; i++) begin
            pkt = {$urandom, $urandom, $urandom, 32'(1000 + i)};
            @(negedge clk);
            Packet = pkt; PkAvail = 1'b1;
            repeat (3) @(negedge clk);
            checkOutput("conc_frame", Frame, sbQueue.pop_front());
            sbQueue.push_back(pkt);
            FrameNext = 1'b1;
            @(negedge clk);
            FrameNext = 1'b0; PkAvail = 1'b0;
            checkOutput("conc_cnt", 128'(FramesCnt), 128'd256);
            repeat (3) @(negedge clk);
        end
        drainAll("conc_drain");

        popFrame();
        checkOutput("final_empty_pop", 128'(FramesCnt), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
